// File: rtl/ecc_scrub_queue.sv
// Scrub write-back queue fed by the SEC-DED load checker: corrected single-bit
// errors are queued (coalesced by address) and replayed to memory; DEDs go to sticky status.
module ecc_scrub_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic                       special_load,
  input  logic [31:0]                sec_corrected_data,
  input  logic [6:0]                 sec_corrected_parity,
  input  logic                       single_error,
  input  logic                       DED_exception,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic [31:0]                wb_data,
  output logic [6:0]                 wb_parity,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       ded_flag,
  output logic [ADDR_W-1:0]          ded_addr,
  output logic                       overflow,
  input  logic                       clr_status
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [6:0]        par_q  [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  head, tail;

  logic             scrub_req, ded_event, pop, push, coalesce, drop, full;
  logic             match_hit;
  logic [PTR_W-1:0] match_idx;

  assign scrub_req = ld_valid & single_error & ~DED_exception & ~special_load;
  assign ded_event = ld_valid & DED_exception & ~special_load;
  assign full      = (pending == CNT_W'(DEPTH));
  assign pop       = wb_valid & wb_ready;

  // Addresses are unique among valid entries, so at most one entry matches.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!match_hit && vld_q[i] && addr_q[i] == ld_addr) begin
        match_hit = 1'b1;
        match_idx = PTR_W'(i);
      end
    end
  end

  // A match on the head that is leaving this cycle becomes a fresh tail entry.
  always_comb begin
    coalesce = scrub_req & match_hit & ~(pop & (match_idx == head));
    push     = scrub_req & ~coalesce & (~full | pop);
    drop     = scrub_req & ~coalesce & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      pending <= '0;
      vld_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        par_q[i]  <= '0;
      end
    end else begin
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (coalesce) begin
        data_q[match_idx] <= sec_corrected_data;
        par_q[match_idx]  <= sec_corrected_parity;
      end
      if (push) begin
        vld_q[tail]  <= 1'b1;
        addr_q[tail] <= ld_addr;
        data_q[tail] <= sec_corrected_data;
        par_q[tail]  <= sec_corrected_parity;
        tail         <= tail + PTR_W'(1);
      end
      if (push && !pop)
        pending <= pending + CNT_W'(1);
      else if (pop && !push)
        pending <= pending - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ded_flag <= 1'b0;
      ded_addr <= '0;
      overflow <= 1'b0;
    end else begin
      if (ded_event && (!ded_flag || clr_status)) begin
        ded_flag <= 1'b1;
        ded_addr <= ld_addr;
      end else if (clr_status) begin
        ded_flag <= 1'b0;
        ded_addr <= '0;
      end
      if (drop)
        overflow <= 1'b1;
      else if (clr_status)
        overflow <= 1'b0;
    end
  end

  always_comb begin
    wb_valid  = (pending != '0);
    wb_addr   = wb_valid ? addr_q[head] : '0;
    wb_data   = wb_valid ? data_q[head] : '0;
    wb_parity = wb_valid ? par_q[head]  : '0;
  end

endmodule

// File: tb/tb_ecc_scrub_queue.sv
// Directed bench for ecc_scrub_queue: queueing, coalescing, overflow, DED status and reset.
module tb_ecc_scrub_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              special_load;
  logic [31:0]       sec_corrected_data;
  logic [6:0]        sec_corrected_parity;
  logic              single_error;
  logic              DED_exception;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [31:0]       wb_data;
  logic [6:0]        wb_parity;
  logic [2:0]        pending;
  logic              ded_flag;
  logic [ADDR_W-1:0] ded_addr;
  logic              overflow;
  logic              clr_status;

  int checks = 0;
  int errors = 0;

  ecc_scrub_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ld_valid            (ld_valid),
    .ld_addr             (ld_addr),
    .special_load        (special_load),
    .sec_corrected_data  (sec_corrected_data),
    .sec_corrected_parity(sec_corrected_parity),
    .single_error        (single_error),
    .DED_exception       (DED_exception),
    .wb_valid            (wb_valid),
    .wb_ready            (wb_ready),
    .wb_addr             (wb_addr),
    .wb_data             (wb_data),
    .wb_parity           (wb_parity),
    .pending             (pending),
    .ded_flag            (ded_flag),
    .ded_addr            (ded_addr),
    .overflow            (overflow),
    .clr_status          (clr_status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid             = 1'b0;
    ld_addr              = '0;
    special_load         = 1'b0;
    sec_corrected_data   = '0;
    sec_corrected_parity = '0;
    single_error         = 1'b0;
    DED_exception        = 1'b0;
    wb_ready             = 1'b0;
    clr_status           = 1'b0;
  endtask

  task automatic drive_ld(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [6:0] p, input logic se, input logic ded);
    ld_valid             = 1'b1;
    ld_addr              = a;
    sec_corrected_data   = d;
    sec_corrected_parity = p;
    single_error         = se;
    DED_exception        = ded;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %0b exp 0", wb_valid); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", pending); end
    checks++; if (wb_addr !== 32'h0 || wb_data !== 32'h0 || wb_parity !== 7'h0) begin
      errors++; $display("FAIL reset_wb_fields got %h/%h/%h exp 0/0/0", wb_addr, wb_data, wb_parity); end
    checks++; if (ded_flag !== 1'b0 || ded_addr !== 32'h0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_status got %b/%h/%b exp 0/0/0", ded_flag, ded_addr, overflow); end
  endtask

  task automatic test_single();
    drive_ld(32'h100, 32'h0, 7'b0000000, 1'b1, 1'b0);
    tick();
    idle();
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 32'h100 || pending !== 3'd1) begin
      errors++; $display("FAIL single_enq got v=%b a=%h p=%0d exp v=1 a=100 p=1", wb_valid, wb_addr, pending); end
    wb_ready = 1'b1;
    tick();
    idle();
    checks++; if (wb_valid !== 1'b0 || pending !== 3'd0 || wb_addr !== 32'h0) begin
      errors++; $display("FAIL single_pop got v=%b p=%0d a=%h exp v=0 p=0 a=0", wb_valid, pending, wb_addr); end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] exp_order [4];
    for (int unsigned i = 1; i <= 5; i++) begin
      drive_ld(32'(i * 16), 32'(i * 16 + 1), 7'(i), 1'b1, 1'b0);
      tick();
    end
    idle();
    checks++; if (pending !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_full got p=%0d ovf=%b exp p=4 ovf=1", pending, overflow); end
    checks++; if (wb_addr !== 32'h10 || wb_data !== 32'h11 || wb_parity !== 7'd1) begin
      errors++; $display("FAIL ovf_head got %h/%h/%h exp 10/11/01", wb_addr, wb_data, wb_parity); end
    clr_status = 1'b1;
    tick();
    idle();
    checks++; if (overflow !== 1'b0 || pending !== 3'd4) begin
      errors++; $display("FAIL ovf_clr got ovf=%b p=%0d exp ovf=0 p=4", overflow, pending); end
    // full queue with a pop in the same cycle accepts the request
    drive_ld(32'h60, 32'h61, 7'd6, 1'b1, 1'b0);
    wb_ready = 1'b1;
    tick();
    idle();
    checks++; if (pending !== 3'd4 || overflow !== 1'b0 || wb_addr !== 32'h20) begin
      errors++; $display("FAIL full_pushpop got p=%0d ovf=%b a=%h exp p=4 ovf=0 a=20", pending, overflow, wb_addr); end
    exp_order[0] = 32'h20; exp_order[1] = 32'h30; exp_order[2] = 32'h40; exp_order[3] = 32'h60;
    for (int unsigned i = 0; i < 4; i++) begin
      checks++; if (wb_valid !== 1'b1 || wb_addr !== exp_order[i]) begin
        errors++; $display("FAIL drain_order[%0d] got v=%b a=%h exp v=1 a=%h", i, wb_valid, wb_addr, exp_order[i]); end
      wb_ready = 1'b1;
      tick();
      idle();
    end
    checks++; if (pending !== 3'd0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty got p=%0d v=%b exp p=0 v=0", pending, wb_valid); end
  endtask

  task automatic test_coalesce();
    drive_ld(32'h10, 32'h1, 7'b0000001, 1'b1, 1'b0);
    tick();
    drive_ld(32'h10, 32'h6, 7'b1000101, 1'b1, 1'b0);
    tick();
    idle();
    checks++; if (pending !== 3'd1 || wb_data !== 32'h6 || wb_parity !== 7'b1000101) begin
      errors++; $display("FAIL coalesce got p=%0d d=%h par=%b exp p=1 d=6 par=1000101", pending, wb_data, wb_parity); end
  endtask

  task automatic test_head_pop_coalesce();
    drive_ld(32'h10, 32'h2, 7'b0000010, 1'b1, 1'b0);
    wb_ready = 1'b1;
    tick();
    idle();
    checks++; if (pending !== 3'd1 || wb_addr !== 32'h10 || wb_data !== 32'h2) begin
      errors++; $display("FAIL head_pop_req got p=%0d a=%h d=%h exp p=1 a=10 d=2", pending, wb_addr, wb_data); end
  endtask

  task automatic test_back_to_back();
    drive_ld(32'hB0, 32'hB1, 7'd11, 1'b1, 1'b0);
    wb_ready = 1'b1;
    tick();
    idle();
    checks++; if (pending !== 3'd1 || wb_addr !== 32'hB0 || wb_data !== 32'hB1) begin
      errors++; $display("FAIL push_pop got p=%0d a=%h d=%h exp p=1 a=b0 d=b1", pending, wb_addr, wb_data); end
    // non-head coalesce: A0 queued behind B0, then A0 updated
    drive_ld(32'hA0, 32'hA1, 7'd1, 1'b1, 1'b0);
    tick();
    drive_ld(32'hA0, 32'hA2, 7'd2, 1'b1, 1'b0);
    tick();
    idle();
    wb_ready = 1'b1;
    tick();
    idle();
    checks++; if (pending !== 3'd1 || wb_addr !== 32'hA0 || wb_data !== 32'hA2 || wb_parity !== 7'd2) begin
      errors++; $display("FAIL nonhead_coalesce got p=%0d a=%h d=%h par=%h exp p=1 a=a0 d=a2 par=02", pending, wb_addr, wb_data, wb_parity); end
    wb_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_ded();
    drive_ld(32'h200, 32'h0, 7'h0, 1'b0, 1'b1);
    tick();
    drive_ld(32'h300, 32'h0, 7'h0, 1'b0, 1'b1);
    tick();
    idle();
    checks++; if (ded_flag !== 1'b1 || ded_addr !== 32'h200 || pending !== 3'd0) begin
      errors++; $display("FAIL ded_first got f=%b a=%h p=%0d exp f=1 a=200 p=0", ded_flag, ded_addr, pending); end
    drive_ld(32'h400, 32'h0, 7'h0, 1'b0, 1'b1);
    clr_status = 1'b1;
    tick();
    idle();
    checks++; if (ded_flag !== 1'b1 || ded_addr !== 32'h400) begin
      errors++; $display("FAIL ded_clr_race got f=%b a=%h exp f=1 a=400", ded_flag, ded_addr); end
    drive_ld(32'h500, 32'h5, 7'h5, 1'b1, 1'b1);
    tick();
    idle();
    checks++; if (pending !== 3'd0 || ded_addr !== 32'h400) begin
      errors++; $display("FAIL ded_and_se got p=%0d a=%h exp p=0 a=400", pending, ded_addr); end
    clr_status = 1'b1;
    tick();
    idle();
    checks++; if (ded_flag !== 1'b0 || ded_addr !== 32'h0) begin
      errors++; $display("FAIL ded_clear got f=%b a=%h exp f=0 a=0", ded_flag, ded_addr); end
  endtask

  task automatic test_filter();
    drive_ld(32'h700, 32'h7, 7'h7, 1'b1, 1'b0);
    special_load = 1'b1;
    tick();
    idle();
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL special_load got p=%0d exp 0", pending); end
    drive_ld(32'h800, 32'h8, 7'h8, 1'b1, 1'b0);
    ld_valid = 1'b0;
    tick();
    idle();
    checks++; if (pending !== 3'd0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL no_ld_valid got p=%0d v=%b exp p=0 v=0", pending, wb_valid); end
  endtask

  task automatic test_reset_mid();
    for (int unsigned i = 1; i <= 3; i++) begin
      drive_ld(32'(i * 32'h1000), 32'(i), 7'(i), 1'b1, 1'b0);
      tick();
    end
    idle();
    checks++; if (pending !== 3'd3) begin errors++; $display("FAIL mid_fill got p=%0d exp 3", pending); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (pending !== 3'd0 || wb_valid !== 1'b0 || wb_addr !== 32'h0) begin
      errors++; $display("FAIL mid_reset got p=%0d v=%b a=%h exp p=0 v=0 a=0", pending, wb_valid, wb_addr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_coalesce();
    test_head_pop_coalesce();
    test_back_to_back();
    test_ded();
    test_filter();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_scrub_queue.md
# ecc_scrub_queue

Downstream consumer of the SEC-DED load checker. Watches each checked load; when a single-bit error was corrected, it queues the corrected data and parity with the load address. It then presents them, in order, as scrub write-backs to the memory write port so the stored word is repaired. Double-bit errors are never queued; the block records them in sticky status for the exception logic.

## Interface
Parameters:
- ADDR_W, 32, load/scrub address width
- DEPTH, 4, queue entries; power of two, ≥ 2

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- ld_valid  in  1  checker outputs below are valid this cycle
- ld_addr  in  ADDR_W  address of the checked load
- special_load  in  1  raw/uncorrected load; never scrubbed
- sec_corrected_data  in  32  corrected data from checker
- sec_corrected_parity  in  7  corrected parity from checker
- single_error  in  1  checker corrected one bit
- DED_exception  in  1  checker detected an uncorrectable error
- wb_valid  out  1  scrub write pending at queue head
- wb_ready  in  1  memory accepts the scrub write this cycle
- wb_addr  out  ADDR_W  head entry address
- wb_data  out  32  head entry data
- wb_parity  out  7  head entry parity
- pending  out  $clog2(DEPTH+1)  valid entries in the queue
- ded_flag  out  1  sticky: a DED was seen
- ded_addr  out  ADDR_W  address of the first DED since the last clear
- overflow  out  1  sticky: a scrub request was dropped because the queue was full
- clr_status  in  1  clears ded_flag, ded_addr and overflow

## Operation
- Request qualifiers:
  - Scrub request: ld_valid & single_error & ~DED_exception & ~special_load.
  - DED event: ld_valid & DED_exception & ~special_load.
- Queue:
  - Circular FIFO with head/tail pointers and a per-entry valid bit.
  - Entry = {addr, data, parity}.
  - Pop: wb_valid & wb_ready advances head and clears that entry's valid bit.
- Coalescing: when a scrub request's ld_addr equals the address of a valid entry, that entry's data and parity are overwritten in place. No new entry is added and pending does not change.
  - Exception: if the matching entry is the head and it pops in the same cycle, the request is enqueued as a new entry at the tail instead.
- Full: a non-coalescing request arriving with pending == DEPTH and no pop this cycle is dropped and overflow is set.
  - If a pop happens the same cycle, the request is accepted: pending stays DEPTH and no overflow is flagged.
- Simultaneous push and pop on a non-full queue: both take effect; pending is unchanged.
- DED handling:
  - The first DED event with ded_flag == 0 captures ld_addr into ded_addr and sets ded_flag.
  - Later DEDs do not change ded_addr until the status is cleared.
  - A DED event never enqueues anything.
- clr_status: clears ded_flag and overflow, and sets ded_addr to 0.
  - If a DED event arrives in the same cycle, the new DED wins: ded_flag = 1 and ded_addr = the new address.
  - If an overflow occurs in the same cycle, overflow = 1.
  - clr_status does not affect queue contents.
- Outputs:
  - wb_valid = (pending != 0).
  - wb_addr, wb_data and wb_parity come from the head entry. They hold stable while wb_valid & ~wb_ready.
  - When the queue is empty, these outputs are 0.
- Assertions: single_error & DED_exception asserted together is treated as a DED event only.

## Timing
- Reset (synchronous, takes effect at the next rising edge):
  - Pointers, valid bits and all outputs are cleared: wb_valid = 0, wb_addr/wb_data/wb_parity = 0, pending = 0, ded_flag = 0, ded_addr = 0, overflow = 0.
  - Reset asserted mid-operation discards all queued entries; no further write-backs are issued.
  - Inputs are ignored during the reset cycle.
- Enqueue latency:
  - A request sampled at edge N appears with wb_valid = 1 after edge N when the queue was empty: one cycle from ld_valid to wb_valid.
  - A coalesced update to the head entry is visible on wb_data from the cycle after edge N.
- Pop: the handshake completes at the edge where wb_valid & wb_ready are both high. The next entry, if any, is presented immediately after that edge.
- Throughput: one enqueue and one pop per cycle.
- Status: ded_flag, ded_addr and overflow update at the sampling edge, so they are visible one cycle after the causing event.
- Datapath: no combinational path from ld_* to wb_*. wb_ready combinationally affects only internal next-state logic, not outputs in the same cycle.

## Test plan
- Reset, then one scrub request (ld_addr = 0x100, data = 0x0, parity = 7'b0000000, single_error = 1) → next cycle wb_valid = 1, wb_addr = 0x100, pending = 1. With wb_ready = 1 for one cycle → wb_valid = 0, pending = 0.
- With wb_ready = 0, send requests to 0x10, 0x20, 0x30, 0x40, 0x50 (DEPTH = 4) → pending = 4, overflow = 1, and the 0x50 request is lost. Then drain with wb_ready = 1 → addresses pop in order 0x10, 0x20, 0x30, 0x40.
- Queue holding 0x10 (data 0x1), second request to 0x10 with data 0x6 / parity 7'b1000101 → pending stays 1, wb_data = 0x6, wb_parity = 7'b1000101.
- Head 0x10 popping in the same cycle as a new 0x10 request (data 0x2) → after the edge pending = 1, wb_addr = 0x10, wb_data = 0x2.
- DED at 0x200, then DED at 0x300 → ded_flag = 1, ded_addr = 0x200, pending = 0. clr_status together with a DED at 0x400 → ded_flag = 1, ded_addr = 0x400.
- special_load = 1 with single_error = 1, and a separate ld_valid = 0 with single_error = 1 → no entry queued in either case (pending = 0); reset asserted with 3 entries queued → pending = 0 and wb_valid = 0 the next cycle.
